// File: rtl/jtframe_objline_draw.sv
// Per-scanline object engine: walks the object table, fetches one 16-pixel row
// for every object crossing the next line and writes its opaque pixels out.
module jtframe_objline_draw #(
    parameter int OBJAW = 6,
    parameter int CODEW = 12,
    parameter int PALW  = 3,
    parameter int BUFAW = 9,
    parameter int LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs,
    input  logic [7:0]       vrender,
    input  logic             flip,
    output logic [OBJAW-1:0] scan_addr,
    input  logic [47:0]      scan_dout,
    output logic             rom_cs,
    output logic [CODEW+4:0] rom_addr,
    input  logic [31:0]      rom_data,
    input  logic             rom_ok,
    output logic [BUFAW-1:0] buf_addr,
    output logic [PALW+3:0]  buf_din,
    output logic             buf_we,
    output logic             ovf,
    output logic             done
);
    localparam int CNTW = $clog2(LIMIT + 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, FETCH, DRAW, NEXT, DONE} state_t;

    state_t           state_q, state_d;
    logic [OBJAW-1:0] idx_q, idx_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d, done_q, done_d, rom_cs_q, rom_cs_d;
    logic [CODEW+4:0] rom_addr_q, rom_addr_d, last_addr_q, last_addr_d;
    logic [63:0]      pix_q, pix_d;
    logic [BUFAW-1:0] x_q, x_d, buf_addr_q, buf_addr_d;
    logic [PALW-1:0]  pal_q, pal_d;
    logic             hflip_q, hflip_d, buf_we_q, buf_we_d;
    logic [3:0]       i_q, i_d;
    logic [PALW+3:0]  buf_din_q, buf_din_d;

    // Entry decode, valid while scan_addr is held after READ
    logic [7:0]       ent_y, ydiff;
    logic [BUFAW-1:0] ent_x;
    logic [CODEW-1:0] ent_code, code_eff;
    logic [PALW-1:0]  ent_pal;
    logic             ent_hflip, ent_vflip, ent_tall, ent_en, hit;
    logic [4:0]       row;
    logic             unused_scan;

    assign ent_y     = scan_dout[7:0];
    assign ent_x     = scan_dout[8 +: BUFAW];
    assign ent_code  = scan_dout[17 +: CODEW];
    assign ent_pal   = scan_dout[33 +: PALW];
    assign ent_hflip = scan_dout[37];
    assign ent_vflip = scan_dout[38];
    assign ent_tall  = scan_dout[39];
    assign ent_en    = scan_dout[40];
    assign unused_scan = ^scan_dout;

    assign ydiff    = vrender - ent_y;
    assign hit      = ent_en && (ent_tall ? (ydiff < 8'd32) : (ydiff < 8'd16));
    assign row      = ent_vflip ? ((ent_tall ? 5'd31 : 5'd15) - ydiff[4:0]) : ydiff[4:0];
    assign code_eff = ent_tall ? {ent_code[CODEW-1:1], row[4]} : ent_code;

    // Horizontal flip reads the pixel row backwards: 15-i == ~i on 4 bits
    logic [3:0]       sel, pix;
    logic [BUFAW-1:0] draw_a;

    assign sel    = hflip_q ? ~i_q : i_q;
    assign pix    = pix_q[{sel, 2'b00} +: 4];
    assign draw_a = x_q + BUFAW'(i_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        done_d      = done_q;
        rom_cs_d    = rom_cs_q;
        rom_addr_d  = rom_addr_q;
        last_addr_d = rom_addr_q;
        pix_d       = pix_q;
        x_d         = x_q;
        pal_d       = pal_q;
        hflip_d     = hflip_q;
        i_d         = i_q;
        buf_addr_d  = buf_addr_q;
        buf_din_d   = buf_din_q;
        buf_we_d    = 1'b0;

        case (state_q)
            READ:  state_d = WAIT;
            WAIT:  state_d = CHECK;
            CHECK: begin
                if (hit && count_q == CNTW'(LIMIT)) begin
                    ovf_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (hit) begin
                    count_d    = count_q + CNTW'(1);
                    x_d        = ent_x;
                    pal_d      = ent_pal;
                    hflip_d    = ent_hflip;
                    rom_addr_d = {code_eff, row[3:0], 1'b0};
                    rom_cs_d   = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = NEXT;
                end
            end
            FETCH: begin
                // rom_ok only counts once the address has been stable for a cycle
                if (rom_ok && rom_addr_q == last_addr_q) begin
                    if (!rom_addr_q[0]) begin
                        pix_d[31:0]   = rom_data;
                        rom_addr_d[0] = 1'b1;
                    end else begin
                        pix_d[63:32] = rom_data;
                        rom_cs_d     = 1'b0;
                        i_d          = 4'd0;
                        state_d      = DRAW;
                    end
                end
            end
            DRAW: begin
                buf_addr_d = flip ? ~draw_a : draw_a;
                buf_din_d  = {pal_q, pix};
                buf_we_d   = |pix;
                i_d        = i_q + 4'd1;
                if (i_q == 4'd15) state_d = NEXT;
            end
            NEXT: begin
                if (&idx_q) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + OBJAW'(1);
                    state_d = READ;
                end
            end
            default: ;
        endcase

        if (hs) begin
            state_d  = READ;
            idx_d    = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            done_d   = 1'b0;
            rom_cs_d = 1'b0;
            buf_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            rom_cs_q    <= 1'b0;
            rom_addr_q  <= '0;
            last_addr_q <= '0;
            pix_q       <= '0;
            x_q         <= '0;
            pal_q       <= '0;
            hflip_q     <= 1'b0;
            i_q         <= '0;
            buf_addr_q  <= '0;
            buf_din_q   <= '0;
            buf_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            rom_cs_q    <= rom_cs_d;
            rom_addr_q  <= rom_addr_d;
            last_addr_q <= last_addr_d;
            pix_q       <= pix_d;
            x_q         <= x_d;
            pal_q       <= pal_d;
            hflip_q     <= hflip_d;
            i_q         <= i_d;
            buf_addr_q  <= buf_addr_d;
            buf_din_q   <= buf_din_d;
            buf_we_q    <= buf_we_d;
        end
    end

    assign scan_addr = idx_q;
    assign rom_cs    = rom_cs_q;
    assign rom_addr  = rom_addr_q;
    assign buf_addr  = buf_addr_q;
    assign buf_din   = buf_din_q;
    assign buf_we    = buf_we_q;
    assign ovf       = ovf_q;
    assign done      = done_q;
endmodule

// File: tb/tb_jtframe_objline_draw.sv
// Directed bench for jtframe_objline_draw: table and ROM models, write/ROM logs,
// one task per scenario with hand-computed expectations.
module tb_jtframe_objline_draw;
    localparam int OBJAW = 6, CODEW = 12, PALW = 3, BUFAW = 9, LIMIT = 32;

    logic             clk = 1'b0, rst_n = 1'b0, hs = 1'b0, flip = 1'b0;
    logic [7:0]       vrender = 8'h00;
    logic [OBJAW-1:0] scan_addr;
    logic [47:0]      scan_dout;
    logic             rom_cs, rom_ok;
    logic [CODEW+4:0] rom_addr;
    logic [31:0]      rom_data;
    logic [BUFAW-1:0] buf_addr;
    logic [PALW+3:0]  buf_din;
    logic             buf_we, ovf, done;

    logic             rom_auto = 1'b1, rom_ok_man = 1'b0;
    logic [31:0]      rom_data_man = 32'h0;
    logic [47:0]      tbl [0:63];
    int               errors = 0, checks = 0;
    logic [BUFAW-1:0] wr_addr [$];
    logic [PALW+3:0]  wr_data [$];
    logic [CODEW+4:0] rom_log [$];

    jtframe_objline_draw #(.OBJAW(OBJAW), .CODEW(CODEW), .PALW(PALW), .BUFAW(BUFAW), .LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .hs(hs), .vrender(vrender), .flip(flip),
        .scan_addr(scan_addr), .scan_dout(scan_dout),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) scan_dout <= tbl[scan_addr];

    assign rom_ok   = rom_auto ? rom_cs : rom_ok_man;
    assign rom_data = rom_auto ? (rom_addr[0] ? 32'h0FEDCBA9 : 32'h87654321) : rom_data_man;

    always @(negedge clk) begin
        if (buf_we) begin
            wr_addr.push_back(buf_addr);
            wr_data.push_back(buf_din);
        end
        if (rom_cs && (rom_log.size() == 0 || rom_addr != rom_log[$]))
            rom_log.push_back(rom_addr);
    end

    function automatic logic [47:0] mk(input logic [7:0] y, input logic [8:0] x, input logic [15:0] code,
                                       input logic [3:0] pal, input logic hf, input logic vf,
                                       input logic tall, input logic en);
        mk = {7'd0, en, tall, vf, hf, pal, code, x, y};
    endfunction

    task automatic clear_table();
        for (int k = 0; k < 64; k++) tbl[k] = 48'h0;
    endtask

    task automatic pulse_hs();
        @(negedge clk); hs = 1'b1;
        @(negedge clk); hs = 1'b0;
        wr_addr.delete(); wr_data.delete(); rom_log.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rom_cs !== 1'b0)   begin errors++; $display("FAIL reset_rom_cs: got %b want 0", rom_cs); end
        checks++; if (buf_we !== 1'b0)   begin errors++; $display("FAIL reset_buf_we: got %b want 0", buf_we); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (scan_addr !== '0)  begin errors++; $display("FAIL reset_scan_addr: got %h want 0", scan_addr); end
        checks++; if (rom_addr !== '0)   begin errors++; $display("FAIL reset_rom_addr: got %h want 0", rom_addr); end
        checks++; if (buf_addr !== '0)   begin errors++; $display("FAIL reset_buf_addr: got %h want 0", buf_addr); end
        checks++; if (buf_din !== '0)    begin errors++; $display("FAIL reset_buf_din: got %h want 0", buf_din); end
        @(negedge clk); rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (done !== 1'b0 || scan_addr !== '0 || rom_cs !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got done=%b scan_addr=%h rom_cs=%b want 0/0/0", done, scan_addr, rom_cs);
        end
        $display("test_reset complete");
    endtask

    task automatic test_basic();
        bit ok, seen1f;
        clear_table();
        tbl[0] = mk(8'h40, 9'h010, 16'h123, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        vrender = 8'h45; flip = 1'b0;
        pulse_hs();
        wait_done(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done: got done=%b want 1", done); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        checks++;
        if (rom_log.size() != 2) begin
            errors++; $display("FAIL basic_rom_count: got %0d want 2", rom_log.size());
        end else begin
            checks++; if (rom_log[0] !== 17'h0246A) begin errors++; $display("FAIL basic_rom0: got %h want 0246a", rom_log[0]); end
            checks++; if (rom_log[1] !== 17'h0246B) begin errors++; $display("FAIL basic_rom1: got %h want 0246b", rom_log[1]); end
        end
        checks++;
        if (wr_addr.size() != 15) begin
            errors++; $display("FAIL basic_wr_count: got %0d want 15", wr_addr.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (wr_addr[i] !== BUFAW'(16 + i) || wr_data[i] !== {3'd5, 4'(i + 1)}) begin
                    errors++; $display("FAIL basic_wr%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], BUFAW'(16 + i), {3'd5, 4'(i + 1)});
                end
            end
        end
        seen1f = 1'b0;
        foreach (wr_addr[k]) if (wr_addr[k] == 9'h01F) seen1f = 1'b1;
        checks++; if (seen1f) begin errors++; $display("FAIL basic_transparent: got write at 01f want none"); end
        $display("test_basic complete: %0d writes", wr_addr.size());
    endtask

    task automatic test_flip();
        bit ok;
        clear_table();
        tbl[0] = mk(8'h40, 9'h010, 16'h123, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        vrender = 8'h45; flip = 1'b1;
        pulse_hs();
        wait_done(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flip_done: got done=%b want 1", done); end
        checks++;
        if (wr_addr.size() != 15) begin
            errors++; $display("FAIL flip_wr_count: got %0d want 15", wr_addr.size());
        end else begin
            for (int i = 1; i < 16; i++) begin
                checks++;
                if (wr_addr[i-1] !== BUFAW'(9'h1EF - i) || wr_data[i-1] !== {3'd5, 4'(16 - i)}) begin
                    errors++; $display("FAIL flip_wr%0d: got %h/%h want %h/%h", i, wr_addr[i-1], wr_data[i-1], BUFAW'(9'h1EF - i), {3'd5, 4'(16 - i)});
                end
            end
        end
        flip = 1'b0;
        $display("test_flip complete: %0d writes", wr_addr.size());
    endtask

    task automatic test_tall_vflip();
        bit ok;
        clear_table();
        tbl[0] = mk(8'h40, 9'h010, 16'h122, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        vrender = 8'h41;
        pulse_hs();
        wait_done(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tall_done: got done=%b want 1", done); end
        checks++;
        if (rom_log.size() != 2) begin
            errors++; $display("FAIL tall_rom_count: got %0d want 2", rom_log.size());
        end else begin
            checks++; if (rom_log[0] !== 17'h0247C) begin errors++; $display("FAIL tall_rom0: got %h want 0247c", rom_log[0]); end
            checks++; if (rom_log[1] !== 17'h0247D) begin errors++; $display("FAIL tall_rom1: got %h want 0247d", rom_log[1]); end
        end
        checks++; if (wr_addr.size() != 15) begin errors++; $display("FAIL tall_wr_count: got %0d want 15", wr_addr.size()); end
        $display("test_tall_vflip complete");
    endtask

    task automatic test_hit_boundary();
        bit ok;
        clear_table();
        tbl[0] = mk(8'h10, 9'h020, 16'h001, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1); // ydiff 16: miss
        tbl[1] = mk(8'h11, 9'h1F8, 16'h002, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1); // ydiff 15: hit, x wraps
        tbl[2] = mk(8'h20, 9'h040, 16'h003, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0); // disabled
        vrender = 8'h20;
        pulse_hs();
        wait_done(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bound_done: got done=%b want 1", done); end
        checks++;
        if (rom_log.size() != 2) begin
            errors++; $display("FAIL bound_rom_count: got %0d want 2", rom_log.size());
        end else begin
            checks++; if (rom_log[0] !== 17'h0005E) begin errors++; $display("FAIL bound_rom0: got %h want 0005e", rom_log[0]); end
        end
        checks++;
        if (wr_addr.size() != 15) begin
            errors++; $display("FAIL bound_wr_count: got %0d want 15", wr_addr.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (wr_addr[i] !== BUFAW'(9'h1F8 + i) || wr_data[i] !== {3'd2, 4'(i + 1)}) begin
                    errors++; $display("FAIL bound_wr%0d: got %h/%h want %h/%h", i, wr_addr[i], wr_data[i], BUFAW'(9'h1F8 + i), {3'd2, 4'(i + 1)});
                end
            end
        end
        $display("test_hit_boundary complete");
    endtask

    task automatic test_limit();
        bit ok;
        clear_table();
        for (int k = 0; k < 40; k++) tbl[k] = mk(8'h40, 9'h010, 16'(k + 1), 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        vrender = 8'h45;
        pulse_hs();
        wait_done(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL limit_done: got done=%b want 1", done); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL limit_ovf: got %b want 1", ovf); end
        checks++; if (wr_addr.size() != 480) begin errors++; $display("FAIL limit_wr_count: got %0d want 480", wr_addr.size()); end
        checks++;
        if (rom_log.size() != 64) begin
            errors++; $display("FAIL limit_rom_count: got %0d want 64", rom_log.size());
        end else begin
            checks++; if (rom_log[63] !== 17'h0040B) begin errors++; $display("FAIL limit_rom_last: got %h want 0040b", rom_log[63]); end
        end
        pulse_hs();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL limit_ovf_clear: got %b want 0", ovf); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL limit_done_clear: got %b want 0", done); end
        $display("test_limit complete");
    endtask

    task automatic test_hs_abort();
        bit ok, found;
        clear_table();
        tbl[0] = mk(8'h40, 9'h010, 16'h123, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        vrender = 8'h45; flip = 1'b0;
        pulse_hs();
        found = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (buf_we && buf_addr == 9'h016) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_draw: got no write at 016 want one"); end
        hs = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL abort_we%0d: got %b want 0", n, buf_we); end
        end
        checks++; if (wr_addr.size() != 7) begin errors++; $display("FAIL abort_partial: got %0d writes want 7", wr_addr.size()); end
        checks++; if (scan_addr !== '0) begin errors++; $display("FAIL abort_idx: got %h want 0", scan_addr); end
        hs = 1'b0;
        wr_addr.delete(); wr_data.delete(); rom_log.delete();
        wait_done(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_rescan_done: got done=%b want 1", done); end
        checks++; if (wr_addr.size() != 15) begin errors++; $display("FAIL abort_rescan_count: got %0d want 15", wr_addr.size()); end
        checks++;
        if (rom_log.size() == 0 || rom_log[0] !== 17'h0246A) begin
            errors++; $display("FAIL abort_rescan_rom: got size %0d want first 0246a", rom_log.size());
        end
        $display("test_hs_abort complete");
    endtask

    task automatic test_reset_fetch();
        bit ok, found;
        clear_table();
        tbl[0] = mk(8'h40, 9'h010, 16'h123, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        vrender = 8'h45;
        rom_auto = 1'b0; rom_ok_man = 1'b0;
        pulse_hs();
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rom_cs) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rstf_reach_fetch: got rom_cs=0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rom_cs !== 1'b0) begin errors++; $display("FAIL rstf_async_cs: got %b want 0", rom_cs); end
        checks++; if (rom_addr !== '0) begin errors++; $display("FAIL rstf_async_addr: got %h want 0", rom_addr); end
        @(negedge clk); rst_n = 1'b1;
        rom_auto = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (done !== 1'b0 || rom_cs !== 1'b0 || wr_addr.size() != 0) begin
            errors++; $display("FAIL rstf_idle: got done=%b rom_cs=%b writes=%0d want 0/0/0", done, rom_cs, wr_addr.size());
        end
        // A rom_ok on the very cycle the address changes must be ignored
        rom_auto = 1'b0; rom_ok_man = 1'b0;
        pulse_hs();
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rom_cs) begin found = 1'b1; break; end
        end
        rom_ok_man = 1'b1; rom_data_man = 32'hFFFFFFFF;
        @(negedge clk); rom_ok_man = 1'b0;
        @(negedge clk);
        checks++; if (rom_addr !== 17'h0246A) begin errors++; $display("FAIL stale_ok_addr: got %h want 0246a", rom_addr); end
        rom_auto = 1'b1;
        wait_done(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stale_done: got done=%b want 1", done); end
        checks++;
        if (wr_addr.size() != 15 || wr_data[0] !== 7'h51) begin
            errors++; $display("FAIL stale_data: got %0d writes want 15 with first data 51", wr_addr.size());
        end
        $display("test_reset_fetch complete");
    endtask

    initial begin
        clear_table();
        test_reset();
        test_basic();
        test_flip();
        test_tall_vflip();
        test_hit_boundary();
        test_limit();
        test_hs_abort();
        test_reset_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1, "watchdog");
    end
endmodule
